// File: rtl/soc_system_sysid_pkg.sv
// rtl/soc_system_sysid_pkg.sv - shared FSM states, address map and default expected words
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    LAT_ID,
    REQ_TS,
    LAT_TS,
    FIN
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd2899645186;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1435110751;

endpackage

// File: rtl/soc_system_avm_single_read.sv
// rtl/soc_system_avm_single_read.sv - single-beat Avalon-MM read engine with stall timeout and fixed read latency
module soc_system_avm_single_read #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_i,
  input  logic addr_i,
  input  logic waitrequest_i,
  output logic read_o,
  output logic address_o,
  output logic accept_o,
  output logic rvalid_o,
  output logic timeout_o
);

  localparam logic [1:0]  LAT_LAST    = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  logic        read_q;
  logic        addr_q;
  logic        lat_active_q;
  logic [1:0]  lat_q;
  logic [15:0] stall_q;
  logic [16:0] stall_d;

  assign stall_d   = {1'b0, stall_q} + 17'd1;
  assign read_o    = read_q;
  assign address_o = addr_q;
  assign accept_o  = read_q & ~waitrequest_i;
  assign timeout_o = read_q & waitrequest_i & (stall_d >= TIMEOUT_LIM);
  assign rvalid_o  = (READ_LATENCY == 0) ? accept_o : (lat_active_q && (lat_q == LAT_LAST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_q       <= 1'b0;
      addr_q       <= 1'b0;
      lat_active_q <= 1'b0;
      lat_q        <= 2'd0;
      stall_q      <= 16'd0;
    end else begin
      if (read_q) begin
        if (waitrequest_i) begin
          if (timeout_o) begin
            read_q <= 1'b0;
          end else if (stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
          end
        end else begin
          read_q <= 1'b0;
          if (READ_LATENCY > 0) begin
            lat_active_q <= 1'b1;
            lat_q        <= 2'd0;
          end
        end
      end
      if (lat_active_q) begin
        if (lat_q == LAT_LAST) lat_active_q <= 1'b0;
        else                   lat_q        <= lat_q + 2'd1;
      end
      // A new issue wins over the accept clear so back-to-back reads keep read high.
      if (issue_i) begin
        read_q  <= 1'b1;
        addr_q  <= addr_i;
        stall_q <= 16'd0;
      end
    end
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// rtl/soc_system_sysid_checker.sv - reads sysid ID/timestamp and flags mismatch; SYSID_CHECK_AUTOSTART_EN adds a post-reset check
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err
);

  state_e      state_q;
  logic        busy_q, done_q, id_match_q, ts_match_q, timeout_err_q;
  logic [31:0] id_value_q, ts_value_q;
  logic        start_d, issue_d, eng_addr_d;
  logic        eng_accept, eng_rvalid, eng_timeout;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_q <= 1'b1;
    else          auto_q <= 1'b0;
  end
  assign start_d = start | auto_q;
`else
  assign start_d = start;
`endif

  assign issue_d    = ((state_q == IDLE) && start_d) ||
                      (((state_q == REQ_ID) || (state_q == LAT_ID)) && eng_rvalid);
  assign eng_addr_d = (state_q == IDLE) ? ADDR_ID : ADDR_TS;

  soc_system_avm_single_read #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .issue_i       (issue_d),
    .addr_i        (eng_addr_d),
    .waitrequest_i (avm_waitrequest),
    .read_o        (avm_read),
    .address_o     (avm_address),
    .accept_o      (eng_accept),
    .rvalid_o      (eng_rvalid),
    .timeout_o     (eng_timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_d) begin
          id_value_q    <= 32'd0;
          ts_value_q    <= 32'd0;
          id_match_q    <= 1'b0;
          ts_match_q    <= 1'b0;
          timeout_err_q <= 1'b0;
          busy_q        <= 1'b1;
          state_q       <= REQ_ID;
        end
        REQ_ID, LAT_ID: begin
          if (eng_timeout) begin
            timeout_err_q <= 1'b1;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= FIN;
          end else if (eng_rvalid) begin
            id_value_q <= avm_readdata;
            id_match_q <= (avm_readdata == EXPECTED_ID);
            state_q    <= REQ_TS;
          end else if (eng_accept) begin
            state_q <= LAT_ID;
          end
        end
        REQ_TS, LAT_TS: begin
          // A timeout on the second word also voids an ID match already recorded.
          if (eng_timeout) begin
            timeout_err_q <= 1'b1;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= FIN;
          end else if (eng_rvalid) begin
            ts_value_q <= avm_readdata;
            ts_match_q <= (avm_readdata == EXPECTED_TS);
            done_q     <= 1'b1;
            state_q    <= FIN;
          end else if (eng_accept) begin
            state_q <= LAT_TS;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout_err = timeout_err_q;

endmodule
